// File: rtl/axi_rd_rr_arbiter.sv
// Round-robin arbiter funnelling N_MST AXI read requesters onto one downstream port.
// One transaction in flight; a stalled downstream read is answered with SLVERR and drained later.
module axi_rd_rr_arbiter #(
    parameter int unsigned N_MST   = 3,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_MST*32-1:0]   m_araddr,
    input  logic [N_MST-1:0]      m_arvalid,
    output logic [N_MST-1:0]      m_arready,
    output logic [31:0]           m_rdata,
    output logic [1:0]            m_rresp,
    output logic [N_MST-1:0]      m_rvalid,
    input  logic [N_MST-1:0]      m_rready,
    output logic [31:0]           s_araddr,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [31:0]           s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    output logic [1:0]            grant_id,
    output logic                  busy,
    output logic [7:0]            timeout_cnt
);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDrain} state_e;

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  last_q, last_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  tcnt_q, tcnt_d;

    logic [N_MST-1:0] sel_mask;
    logic             sel_rready;
    logic             timed_out;
    logic             pick_found;
    logic [1:0]       pick_idx;
    logic [31:0]      pick_addr;
    logic [31:0]      cand;

    // Search starts one past the last granted master so service rotates.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        pick_addr  = 32'd0;
        cand       = 32'd0;
        for (int k = 0; k < N_MST; k++) begin
            cand = (32'(last_q) + 32'(k) + 32'd1) % N_MST;
            for (int i = 0; i < N_MST; i++) begin
                if (!pick_found && cand == 32'(i) && m_arvalid[i]) begin
                    pick_found = 1'b1;
                    pick_idx   = 2'(i);
                    pick_addr  = m_araddr[32*i +: 32];
                end
            end
        end
    end

    always_comb begin
        sel_rready = 1'b0;
        for (int i = 0; i < N_MST; i++) begin
            sel_mask[i] = (grant_q == 2'(i));
            sel_rready  = sel_rready | (m_rready[i] & sel_mask[i]);
        end
    end

    assign timed_out = (state_q == StData) && (timer_q == 16'(TIMEOUT));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        addr_d    = addr_q;
        timer_d   = timer_q;
        tcnt_d    = tcnt_q;
        m_arready = '0;
        m_rvalid  = '0;
        m_rdata   = 32'd0;
        m_rresp   = 2'b00;
        s_araddr  = 32'd0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    addr_d  = pick_addr;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                s_arvalid = 1'b1;
                s_araddr  = addr_q;
                m_arready = sel_mask & {N_MST{s_arready}};
                if (s_arready) begin
                    state_d = StData;
                    timer_d = 16'd0;
                    last_d  = grant_q;
                end
            end
            StData: begin
                if (timed_out) begin
                    // Answer the master ourselves; the slave beat is drained later.
                    m_rvalid = sel_mask;
                    m_rresp  = 2'b10;
                    if (sel_rready) begin
                        state_d = StDrain;
                    end
                end else begin
                    m_rdata  = s_rdata;
                    m_rresp  = s_rresp;
                    m_rvalid = sel_mask & {N_MST{s_rvalid}};
                    s_rready = sel_rready;
                    if (s_rvalid && sel_rready) begin
                        state_d = StIdle;
                    end else begin
                        timer_d = timer_q + 16'd1;
                        if (timer_d == 16'(TIMEOUT) && tcnt_q != 8'hFF) begin
                            tcnt_d = tcnt_q + 8'd1;
                        end
                    end
                end
            end
            StDrain: begin
                s_rready = 1'b1;
                if (s_rvalid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            grant_q <= 2'd0;
            last_q  <= 2'(N_MST - 1);
            addr_q  <= 32'd0;
            timer_q <= 16'd0;
            tcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            timer_q <= timer_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign grant_id    = grant_q;
    assign busy        = (state_q != StIdle);
    assign timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_axi_rd_rr_arbiter.sv
// Directed bench for axi_rd_rr_arbiter: a default instance for the normal read
// paths and a TIMEOUT=4 instance, both on shared stimulus, for the timeout path.
module tb_axi_rd_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [95:0] m_araddr;
    logic [2:0]  m_arvalid;
    logic [2:0]  m_rready;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;

    logic [2:0]  m_arready, m_rvalid;
    logic [31:0] m_rdata, s_araddr;
    logic [1:0]  m_rresp, grant_id;
    logic        s_arvalid, s_rready, busy;
    logic [7:0]  timeout_cnt;

    logic [2:0]  m_arready_to, m_rvalid_to;
    logic [31:0] m_rdata_to, s_araddr_to;
    logic [1:0]  m_rresp_to, grant_id_to;
    logic        s_arvalid_to, s_rready_to, busy_to;
    logic [7:0]  timeout_cnt_to;

    int n_cmp = 0;
    int n_err = 0;

    axi_rd_rr_arbiter u_dut (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .grant_id(grant_id), .busy(busy), .timeout_cnt(timeout_cnt)
    );

    axi_rd_rr_arbiter #(.N_MST(3), .TIMEOUT(4)) u_dut_to (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready_to),
        .m_rdata(m_rdata_to), .m_rresp(m_rresp_to), .m_rvalid(m_rvalid_to),
        .m_rready(m_rready),
        .s_araddr(s_araddr_to), .s_arvalid(s_arvalid_to), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready_to),
        .grant_id(grant_id_to), .busy(busy_to), .timeout_cnt(timeout_cnt_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int seq [4] = '{0, 1, 2, 0};

    initial begin
        rst       = 1'b0;
        m_araddr  = '0;
        m_arvalid = '0;
        m_rready  = '0;
        s_arready = 1'b0;
        s_rdata   = 32'h0000_1234;
        s_rresp   = 2'b11;
        s_rvalid  = 1'b1;
        repeat (3) tick();
        #1;
        // Reset values, even with slave data/valid present
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_arready", 32'(m_arready), 32'd0);
        check("rst_rvalid", 32'(m_rvalid), 32'd0);
        check("rst_s_arvalid", 32'(s_arvalid), 32'd0);
        check("rst_s_araddr", s_araddr, 32'd0);
        check("rst_s_rready", 32'(s_rready), 32'd0);
        check("rst_rdata", m_rdata, 32'd0);
        check("rst_rresp", 32'(m_rresp), 32'd0);
        check("rst_tcnt", 32'(timeout_cnt), 32'd0);

        // All three masters request; grants rotate 0,1,2,0 at 3 cycles per read
        m_araddr  = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
        m_arvalid = 3'b111;
        m_rready  = 3'b111;
        s_arready = 1'b1;
        s_rvalid  = 1'b1;
        s_rdata   = 32'h0000_A5A5;
        s_rresp   = 2'b00;
        rst       = 1'b1;
        #1;
        for (int j = 0; j < 4; j++) begin
            check("rr_idle_busy", 32'(busy), 32'd0);
            tick();
            check("rr_grant", 32'(grant_id), 32'(seq[j]));
            check("rr_araddr", s_araddr, 32'((seq[j] + 1) << 28));
            check("rr_arready", 32'(m_arready), 32'(1 << seq[j]));
            tick();
            check("rr_rvalid", 32'(m_rvalid), 32'(1 << seq[j]));
            check("rr_rdata", m_rdata, 32'h0000_A5A5);
            tick();
        end
        m_arvalid = 3'b000;

        // Master 1 alone, slave answers after a delay
        s_rvalid  = 1'b0;
        m_rready  = 3'b010;
        m_araddr  = {32'h3000_0000, 32'h8000_0010, 32'h1000_0000};
        m_arvalid = 3'b010;
        tick();
        check("m1_grant", 32'(grant_id), 32'd1);
        check("m1_araddr", s_araddr, 32'h8000_0010);
        check("m1_arready", 32'(m_arready), 32'b010);
        m_arvalid = 3'b000;
        tick();
        check("m1_wait_rvalid", 32'(m_rvalid), 32'd0);
        repeat (4) tick();
        s_rvalid = 1'b1;
        s_rdata  = 32'hDEAD_BEEF;
        s_rresp  = 2'b00;
        #1;
        check("m1_rvalid", 32'(m_rvalid), 32'b010);
        check("m1_rdata", m_rdata, 32'hDEAD_BEEF);
        check("m1_rresp", 32'(m_rresp), 32'd0);
        tick();
        s_rvalid = 1'b0;
        check("m1_done_busy", 32'(busy), 32'd0);

        // m_rready held low: data holds, s_rready stays low; s_rvalid ignored in IDLE/ADDR
        m_rready  = 3'b000;
        s_rvalid  = 1'b1;
        s_rdata   = 32'h55AA_0001;
        s_rresp   = 2'b01;
        m_arvalid = 3'b001;
        #1;
        check("idle_s_rready", 32'(s_rready), 32'd0);
        tick();
        check("addr_s_rready", 32'(s_rready), 32'd0);
        check("bp_grant", 32'(grant_id), 32'd0);
        m_arvalid = 3'b000;
        tick();
        for (int j = 0; j < 3; j++) begin
            check("bp_s_rready", 32'(s_rready), 32'd0);
            check("bp_rvalid", 32'(m_rvalid), 32'b001);
            check("bp_rdata", m_rdata, 32'h55AA_0001);
            check("bp_rresp", 32'(m_rresp), 32'd1);
            tick();
        end
        m_rready = 3'b001;
        #1;
        check("bp_s_rready_hs", 32'(s_rready), 32'd1);
        tick();
        check("bp_done_busy", 32'(busy), 32'd0);
        m_rready = 3'b000;
        s_rvalid = 1'b0;
        s_rresp  = 2'b00;

        // Master 2 drops arvalid in ADDR; latched address still issued
        s_arready = 1'b0;
        m_araddr  = {32'h3000_0044, 32'h8000_0010, 32'h1000_0000};
        m_arvalid = 3'b100;
        tick();
        check("drop_grant", 32'(grant_id), 32'd2);
        m_arvalid = 3'b000;
        m_araddr  = {32'hFFFF_FFFF, 32'h8000_0010, 32'h1000_0000};
        tick();
        check("drop_s_arvalid", 32'(s_arvalid), 32'd1);
        check("drop_araddr", s_araddr, 32'h3000_0044);
        check("drop_arready_lo", 32'(m_arready), 32'd0);
        s_arready = 1'b1;
        #1;
        check("drop_arready", 32'(m_arready), 32'b100);
        tick();
        s_rvalid = 1'b1;
        m_rready = 3'b100;
        s_rdata  = 32'h0BAD_F00D;
        #1;
        check("drop_rvalid", 32'(m_rvalid), 32'b100);
        check("drop_rdata", m_rdata, 32'h0BAD_F00D);
        tick();
        check("drop_done_busy", 32'(busy), 32'd0);
        s_rvalid = 1'b0;
        m_rready = 3'b000;

        // Reset during DATA abandons the read; master 0 wins next
        m_arvalid = 3'b010;
        m_rready  = 3'b010;
        tick();
        m_arvalid = 3'b000;
        tick();
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_grant", 32'(grant_id), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_grant", 32'(grant_id), 32'd0);
        check("mid_rst_rvalid", 32'(m_rvalid), 32'd0);
        check("mid_rst_s_rready", 32'(s_rready), 32'd0);
        tick();
        rst       = 1'b1;
        m_arvalid = 3'b011;
        tick();
        check("post_rst_grant", 32'(grant_id), 32'd0);
        m_arvalid = 3'b000;
        s_rvalid  = 1'b1;
        m_rready  = 3'b111;
        tick();
        tick();
        check("post_rst_idle", 32'(busy), 32'd0);
        s_rvalid = 1'b0;
        m_rready = 3'b000;

        // Timeout path on the TIMEOUT=4 instance
        rst = 1'b0;
        tick();
        rst       = 1'b1;
        s_rdata   = 32'h0000_0077;
        m_arvalid = 3'b001;
        tick();
        m_arvalid = 3'b000;
        tick();
        check("to_wait0", 32'(m_rvalid_to), 32'd0);
        for (int j = 0; j < 3; j++) begin
            tick();
            check("to_wait", 32'(m_rvalid_to), 32'd0);
        end
        tick();
        check("to_rvalid", 32'(m_rvalid_to), 32'b001);
        check("to_rresp", 32'(m_rresp_to), 32'd2);
        check("to_rdata", m_rdata_to, 32'd0);
        check("to_s_rready", 32'(s_rready_to), 32'd0);
        check("to_tcnt", 32'(timeout_cnt_to), 32'd1);
        tick();
        check("to_hold_rvalid", 32'(m_rvalid_to), 32'b001);
        check("to_hold_tcnt", 32'(timeout_cnt_to), 32'd1);
        m_rready = 3'b001;
        tick();
        m_rready = 3'b000;
        check("drain_busy", 32'(busy_to), 32'd1);
        check("drain_rvalid", 32'(m_rvalid_to), 32'd0);
        check("drain_arready", 32'(m_arready_to), 32'd0);
        check("drain_s_rready", 32'(s_rready_to), 32'd1);
        tick();
        check("drain_busy2", 32'(busy_to), 32'd1);
        s_rvalid = 1'b1;
        s_rdata  = 32'h0000_0099;
        #1;
        check("drain_discard_rvalid", 32'(m_rvalid_to), 32'd0);
        check("drain_discard_rdata", m_rdata_to, 32'd0);
        tick();
        s_rvalid = 1'b0;
        check("drain_done_busy", 32'(busy_to), 32'd0);
        check("drain_done_tcnt", 32'(timeout_cnt_to), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
